// File: rtl/lcd_pkg.sv
// Purpose: shared types and constants for the HD44780-style panel responder.
// Contents: FSM state enum, instruction bit positions and decoder, space character,
//           cfg bit indices and reset value, modulo-128 step helper.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_POR   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // Instructions are identified by their highest set bit.
    localparam int unsigned OPB_CLEAR = 0;
    localparam int unsigned OPB_HOME  = 1;
    localparam int unsigned OPB_ENTRY = 2;
    localparam int unsigned OPB_DISP  = 3;
    localparam int unsigned OPB_SHIFT = 4;
    localparam int unsigned OPB_FUNC  = 5;
    localparam int unsigned OPB_CGRAM = 6;
    localparam int unsigned OPB_DDRAM = 7;

    typedef enum logic [3:0] {
        I_NONE, I_CLEAR, I_HOME, I_ENTRY, I_DISP,
        I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
    } instr_e;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam int unsigned DDRAM_DEPTH = 128;

    // cfg = {N, F, D, C, B, I/D, S}
    localparam int unsigned CFG_N  = 6;
    localparam int unsigned CFG_F  = 5;
    localparam int unsigned CFG_D  = 4;
    localparam int unsigned CFG_C  = 3;
    localparam int unsigned CFG_B  = 2;
    localparam int unsigned CFG_ID = 1;
    localparam int unsigned CFG_S  = 0;
    localparam logic [6:0] CFG_RESET = 7'b0000010;

    function automatic instr_e decode_instr(input logic [7:0] d);
        if (d[OPB_DDRAM])      return I_DDRAM;
        else if (d[OPB_CGRAM]) return I_CGRAM;
        else if (d[OPB_FUNC])  return I_FUNC;
        else if (d[OPB_SHIFT]) return I_SHIFT;
        else if (d[OPB_DISP])  return I_DISP;
        else if (d[OPB_ENTRY]) return I_ENTRY;
        else if (d[OPB_HOME])  return I_HOME;
        else if (d[OPB_CLEAR]) return I_CLEAR;
        else                   return I_NONE;
    endfunction

    // Address counter / display offset step; 7-bit arithmetic wraps modulo 128.
    function automatic logic [6:0] step7(input logic [6:0] v, input logic up);
        return up ? (v + 7'd1) : (v - 7'd1);
    endfunction

endpackage

// File: rtl/lcd_panel_responder_ddram.sv
// Purpose: 128x8 display data RAM, one synchronous write port, one asynchronous read port.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o combinational read.
// Contents are not reset; power-on and clear fills arrive through the write port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [6:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [6:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [DDRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_panel_responder.sv
// Purpose: cycle-based HD44780-style panel model; latches host transfers on the falling
//          edge of e, decodes instructions, holds DDRAM, serves reads, models busy time.
// Ports: clk, rst_n (sync, active-low); e/rs/rw/lcd_data_in host bus; lcd_data_out/data_oe
//        read return; busy_flag, ac, display_offset, cfg decoded state; cmd_err, timing_err pulses.
// Optional: LCD_RESP_TIMING_CHECK_EN enables the minimum e-high-width check (timing_err).
module lcd_panel_responder
    import lcd_pkg::*;
#(
    parameter int POR_CYCLES    = 200,
    parameter int EXEC_CYCLES   = 740,
    parameter int CLEAR_CYCLES  = 30400,
    parameter int EN_MIN_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       data_oe,
    output logic       busy_flag,
    output logic [6:0] ac,
    output logic [6:0] display_offset,
    output logic [6:0] cfg,
    output logic       cmd_err,
    output logic       timing_err
);

    // Fills need one cycle per DDRAM address, so POR/clear must cover 128 cycles.
    if (POR_CYCLES < 128) begin : g_bad_por
        $error("POR_CYCLES must be at least 128");
    end
    if (CLEAR_CYCLES < 128) begin : g_bad_clear
        $error("CLEAR_CYCLES must be at least 128");
    end
    if (EXEC_CYCLES < 1) begin : g_bad_exec
        $error("EXEC_CYCLES must be at least 1");
    end
    if (EN_MIN_CYCLES < 1) begin : g_bad_en
        $error("EN_MIN_CYCLES must be at least 1");
    end

    localparam int MAX_AB     = (POR_CYCLES > EXEC_CYCLES) ? POR_CYCLES : EXEC_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > CLEAR_CYCLES) ? MAX_AB : CLEAR_CYCLES;
    // One spare bit so the fill-range compare against 128 never truncates.
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] limit_m1;
    logic          cnt_done;
    logic          e_q;
    logic [6:0]    ac_q, ac_d;
    logic [6:0]    off_q, off_d;
    logic [6:0]    cfg_q, cfg_d;
    logic          oe_q, oe_d;
    logic [7:0]    dout_q, dout_d;
    logic          cmd_err_q, cmd_err_d;
    logic          fall;
    logic          short_pulse;
    logic          xfer;
    logic          idle;
    logic          mem_we;
    logic [6:0]    mem_waddr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    assign fall = e_q & ~e;
    assign idle = (state_q == ST_IDLE);
    // A pulse rejected by the width check is not a transfer at all.
    assign xfer = fall & ~short_pulse;

`ifdef LCD_RESP_TIMING_CHECK_EN
    localparam int EW_W = $clog2(EN_MIN_CYCLES + 1);
    logic [EW_W-1:0] ew_q, ew_d;
    logic            terr_q;

    // Saturating count of consecutive e-high cycles; on the falling-edge cycle
    // ew_q still holds the width of the pulse just ended.
    always_comb begin
        ew_d = '0;
        if (e) begin
            ew_d = (ew_q == EW_W'(EN_MIN_CYCLES)) ? ew_q : (ew_q + 1'b1);
        end
    end

    assign short_pulse = fall & (ew_q < EW_W'(EN_MIN_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ew_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            ew_q   <= ew_d;
            terr_q <= short_pulse;
        end
    end

    assign timing_err = terr_q;
`else
    assign short_pulse = 1'b0;
    assign timing_err  = 1'b0;
`endif

    always_comb begin
        unique case (state_q)
            ST_POR:   limit_m1 = CW'(POR_CYCLES - 1);
            ST_CLEAR: limit_m1 = CW'(CLEAR_CYCLES - 1);
            default:  limit_m1 = CW'(EXEC_CYCLES - 1);
        endcase
    end

    assign cnt_done = (cnt_q == limit_m1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ac_d      = ac_q;
        off_d     = off_q;
        cfg_d     = cfg_q;
        cmd_err_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ac_q;
        mem_wdata = lcd_data_in;

        // Busy timer. The first 128 cycles of POR and CLEAR double as the
        // fill address sequence, one DDRAM location per cycle.
        if (!idle) begin
            if (cnt_done) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((state_q != ST_EXEC) && (cnt_q < CW'(DDRAM_DEPTH))) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[6:0];
                mem_wdata = CHAR_SPACE;
            end
        end

        // Transfers act only from IDLE, so they never collide with the timer
        // or a fill. An expiry in the same cycle still counts as busy.
        if (xfer) begin
            if (!rw) begin
                if (!idle) begin
                    cmd_err_d = 1'b1;
                end else if (!rs) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                    unique case (decode_instr(lcd_data_in))
                        I_CLEAR: begin
                            state_d       = ST_CLEAR;
                            ac_d          = '0;
                            off_d         = '0;
                            cfg_d[CFG_ID] = 1'b1;
                        end
                        I_HOME: begin
                            ac_d  = '0;
                            off_d = '0;
                        end
                        I_ENTRY: begin
                            cfg_d[CFG_ID] = lcd_data_in[1];
                            cfg_d[CFG_S]  = lcd_data_in[0];
                        end
                        I_DISP: begin
                            cfg_d[CFG_D] = lcd_data_in[2];
                            cfg_d[CFG_C] = lcd_data_in[1];
                            cfg_d[CFG_B] = lcd_data_in[0];
                        end
                        I_SHIFT: begin
                            if (lcd_data_in[3]) begin
                                off_d = step7(off_q, lcd_data_in[2]);
                            end else begin
                                ac_d = step7(ac_q, lcd_data_in[2]);
                            end
                        end
                        I_FUNC: begin
                            cfg_d[CFG_N] = lcd_data_in[3];
                            cfg_d[CFG_F] = lcd_data_in[2];
                        end
                        I_DDRAM: begin
                            ac_d = lcd_data_in[6:0];
                        end
                        default: begin
                            // CGRAM address and all-zero byte: accepted, no effect.
                        end
                    endcase
                end else begin
                    state_d   = ST_EXEC;
                    cnt_d     = '0;
                    mem_we    = 1'b1;
                    mem_waddr = ac_q;
                    mem_wdata = lcd_data_in;
                    ac_d      = step7(ac_q, cfg_q[CFG_ID]);
                    if (cfg_q[CFG_S]) begin
                        off_d = step7(off_q, cfg_q[CFG_ID]);
                    end
                end
            end else if (rs) begin
                if (!idle) begin
                    cmd_err_d = 1'b1;
                end else begin
                    ac_d = step7(ac_q, cfg_q[CFG_ID]);
                end
            end
        end
    end

    // Read return is refreshed every cycle e is high with rw=1.
    always_comb begin
        oe_d   = e & rw;
        dout_d = dout_q;
        if (e && rw) begin
            if (rs) begin
                dout_d = idle ? mem_rdata : 8'h00;
            end else begin
                dout_d = {~idle, ac_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_POR;
            cnt_q     <= '0;
            e_q       <= 1'b0;
            ac_q      <= '0;
            off_q     <= '0;
            cfg_q     <= CFG_RESET;
            oe_q      <= 1'b0;
            dout_q    <= 8'h00;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            e_q       <= e;
            ac_q      <= ac_d;
            off_q     <= off_d;
            cfg_q     <= cfg_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    lcd_ddram u_ddram (
        .clk     (clk),
        .we_i    (mem_we & rst_n),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (ac_q),
        .rdata_o (mem_rdata)
    );

    assign busy_flag      = ~idle;
    assign ac             = ac_q;
    assign display_offset = off_q;
    assign cfg            = cfg_q;
    assign data_oe        = oe_q;
    assign lcd_data_out   = dout_q;
    assign cmd_err        = cmd_err_q;

endmodule

// File: doc/lcd_panel_responder.md
# lcd_panel_responder

Cycle-based HD44780-style LCD panel model: the far end of the host LCD controller's e/rs/rw/data bus. It latches writes on the falling edge of `e`, decodes the instruction set and stores characters in a 128-byte DDRAM. It serves busy-flag/address and data reads, and enforces execution times through a busy flag. It sits in the bench/formal harness opposite the host controller and exposes decoded panel state for checking.

## Interface
- `POR_CYCLES`, 200: internal power-on busy time after reset; must be ≥128.
- `EXEC_CYCLES`, 740: busy time for every instruction except clear (37 µs at 20 clk/µs).
- `CLEAR_CYCLES`, 30400: busy time for clear display; must be ≥128.
- `EN_MIN_CYCLES`, 10: minimum `e` high width, used only under the configuration macro.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  **reset, synchronous, active-low**.
- `e`, `rs`, `rw`  in  1 each  host strobe, register select, read/not-write.
- `lcd_data_in`  in  8  host write data.
- `lcd_data_out`  out  8  read data.
- `data_oe`  out  1  read data valid/drive.
- `busy_flag`  out  1  panel busy.
- `ac`  out  7  address counter.
- `display_offset`  out  7  display shift offset.
- `cfg`  out  7  {N, F, D, C, B, I/D, S}.
- `cmd_err`  out  1  one-cycle pulse: transfer dropped because the panel was busy.
- `timing_err`  out  1  one-cycle pulse: short `e` pulse (see Configuration).

## Operation
- Reset values:
  - state POR, busy_flag 1, data_oe 0, lcd_data_out 0.
  - ac 0, display_offset 0.
  - cfg 7'b0000010 (I/D=1, all else 0).
  - cmd_err 0, timing_err 0.
  - DDRAM itself is not reset.
- States: POR → IDLE; IDLE → EXEC or CLEAR; EXEC/CLEAR → IDLE when the counter expires. busy_flag = (state != IDLE).
- POR: fill DDRAM[0..127] with 8'h20, one address per cycle, then wait out POR_CYCLES total.
- Transfer boundary is the falling edge of `e` (registered `e` was 1, current `e` is 0). `rs`, `rw` and `lcd_data_in` are sampled in that cycle.
- Write with rs=0 in IDLE (instruction), decoded on the highest set bit:
  - 1: clear. DDRAM filled with 8'h20, ac=0, offset=0, I/D=1. Goes to CLEAR.
  - 2/3: home. ac=0, offset=0.
  - 4–7: entry mode. I/D=d[1], S=d[0].
  - 8–15: display control. D, C, B = d[2:0].
  - 16–31: shift. If S/C=d[3] is 1, offset ±1 by R/L=d[2]; otherwise ac ±1.
  - 32–63: function set. N=d[3], F=d[2]. DL is ignored.
  - 64–127: CGRAM address. Accepted with no state change.
  - 128+: ac=d[6:0].
  - Every instruction except clear goes to EXEC.
- Write with rs=1 in IDLE (data): DDRAM[ac]=data, ac ±1 per I/D, offset ±1 when S=1. Goes to EXEC.
- Any write while busy is dropped and pulses cmd_err. A falling edge from a read never pulses cmd_err.
- Read, rs=0: always allowed, including while busy. Returns {busy_flag, ac}.
- Read, rs=1: allowed only in IDLE. Returns DDRAM[ac]. On the falling edge, ac ±1 per I/D; the panel stays IDLE. A data read while busy returns 8'h00 and pulses cmd_err.
- Arithmetic: ac and offset wrap modulo 128 (7'h7F+1=0, 0−1=7'h7F).
- Reset mid-operation: rst_n low aborts any state and returns to POR on the next edge.

## Timing
- A write's effects (ac, cfg, DDRAM, busy_flag=1) are visible on the cycle after the falling-edge cycle.
- The busy period lasts exactly EXEC_CYCLES or CLEAR_CYCLES, counted from that cycle. busy_flag drops on the cycle the counter expires.
- data_oe and lcd_data_out are registered. They are valid from the cycle after `e` goes high with rw=1, and are updated each cycle while `e` stays high.
- data_oe drops on the cycle after `e` falls.
- A simultaneous busy expiry and falling edge counts as busy; the transfer is dropped.

## Configuration
- `LCD_RESP_TIMING_CHECK_EN` defined:
  - The `e` high width is counted (saturating).
  - A falling edge after fewer than EN_MIN_CYCLES high cycles pulses timing_err and the transfer is ignored.
- Not defined:
  - timing_err is tied 0 and all pulses are accepted.
  - The width counter is not built.

## Structure
- Package `lcd_pkg` holds:
  - the state enum (POR, IDLE, EXEC, CLEAR);
  - instruction opcode constants;
  - the space character 8'h20;
  - the cfg bit-index constants.
- One sub-module, `lcd_ddram`: 128×8 memory with one synchronous write port and one asynchronous read port. Clear/POR fills go through the same write port.

## Test plan
- Reset held, then released. busy_flag stays 1 for 200 cycles. A busy read then returns 8'h80. DDRAM[0x45] reads 8'h20.
- Write 8'h38, then 8'h0F, then 8'h06, each after busy clears. cfg reads 7'b1111110.
- 8'hC5, then data 8'h41 ('A'). ac becomes 7'h46. Then 8'hC5 and a data read returns 8'h41, with ac 7'h46 afterwards.
- Write 8'h01, then write data after 100 cycles. cmd_err pulses and DDRAM is unchanged. busy_flag lasts 30400 cycles.
- ac=7'h7F, data write with I/D=1 → ac 0. With I/D=0 and ac=0, shift 8'h10 → ac 7'h7F.
- With the macro defined, a 5-cycle `e` pulse on 8'h80 → timing_err pulses and ac is unchanged. Without the macro, ac=0.
